muldiv_sequencer: RTL and testbench

- Iterative multiply/divide controller beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from execute with already-forwarded operands, runs a 32-step shift-add or restoring-divide loop, and owns the HI/LO architectural registers.
- Raises a pipeline stall when a new mul/div op or an HI/LO read arrives while an operation is in flight.

---
 rtl/muldiv_sequencer_if.sv | 31 +++
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide sequencer.
//   master (execute): drives start, op, data_ra, data_rb, hilo_rd, wr_hi, wr_lo, flush;
//                     observes stall, busy, done, hi, lo.
//   slave (sequencer): the reverse direction of every signal above.
interface muldiv_sequencer_if #(
    parameter int unsigned NB_DATA = 32
);
    logic               start;    // valid mul/div op in EX
    logic [1:0]         op;       // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
    logic [NB_DATA-1:0] data_ra;  // rs, post-forwarding
    logic [NB_DATA-1:0] data_rb;  // rt, post-forwarding
    logic               hilo_rd;  // MFHI/MFLO in EX
    logic               wr_hi;    // MTHI
    logic               wr_lo;    // MTLO
    logic               flush;    // squash in-flight op
    logic               stall;    // hold IF/ID/EX
    logic               busy;     // sequencer not idle
    logic               done;     // HI/LO written this cycle
    logic [NB_DATA-1:0] hi;
    logic [NB_DATA-1:0] lo;

    modport master (
        output start, op, data_ra, data_rb, hilo_rd, wr_hi, wr_lo, flush,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, data_ra, data_rb, hilo_rd, wr_hi, wr_lo, flush,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit that sits beside the EX-stage ALU and owns HI/LO.
// One shift-add (multiply) or restoring-divide step per cycle, NB_DATA steps per op.
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-low reset
//   bus      slave side of muldiv_sequencer_if (op request, MTHI/MTLO, MFHI/MFLO,
//            flush in; stall, busy, done, hi, lo out)
module muldiv_sequencer #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_CNT  = 5
) (
    input logic               clock_i,
    input logic               reset_i,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e               state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [NB_DATA-1:0]   acc_q, acc_d;    // product high half / partial remainder
    logic [NB_DATA-1:0]   q_q, q_d;        // multiplier -> product low half / dividend -> quotient
    logic [NB_DATA-1:0]   b_q, b_d;        // multiplicand / divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;  // negate product or quotient
    logic                 neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic                 dz_q, dz_d;            // divide by zero
    logic [NB_DATA-1:0]   hi_q, hi_d;
    logic [NB_DATA-1:0]   lo_q, lo_d;

    logic                 is_signed;
    logic                 sgn_a, sgn_b;
    logic [NB_DATA-1:0]   mag_a, mag_b;
    logic [NB_DATA:0]     add_sum;
    logic [NB_DATA:0]     div_sh;
    logic [NB_DATA:0]     div_trial;
    logic [2*NB_DATA-1:0] prod, prod_neg;

    // Signed ops are MULT (00) and DIV (10).
    assign is_signed = ~bus.op[0];
    assign sgn_a     = is_signed & bus.data_ra[NB_DATA-1];
    assign sgn_b     = is_signed & bus.data_rb[NB_DATA-1];
    assign mag_a     = sgn_a ? -bus.data_ra : bus.data_ra;
    assign mag_b     = sgn_b ? -bus.data_rb : bus.data_rb;

    // Multiply step: conditional add with carry kept in bit NB_DATA for the right shift.
    assign add_sum   = q_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};

    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    assign div_sh    = {acc_q, q_q[NB_DATA-1]};
    assign div_trial = div_sh - {1'b0, b_q};

    assign prod      = {acc_q, q_q};
    assign prod_neg  = -prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                // MTHI/MTLO land even when an op starts this cycle; the result overwrites later.
                if (bus.wr_hi) hi_d = bus.data_ra;
                if (bus.wr_lo) lo_d = bus.data_ra;
                if (bus.start && !bus.flush) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    acc_d     = '0;
                    cnt_d     = '0;
                    q_d       = mag_a;
                    b_d       = mag_b;
                    dz_d      = 1'b0;
                    state_d   = StCalc;
                    if (bus.op[1] && (bus.data_rb == '0)) begin
                        // Keep the raw dividend so HI can return it unmodified.
                        dz_d    = 1'b1;
                        q_d     = bus.data_ra;
                        state_d = StFinish;
                    end
                end
            end

            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    if (!is_div_q) begin
                        acc_d = add_sum[NB_DATA:1];
                        q_d   = {add_sum[0], q_q[NB_DATA-1:1]};
                    end else if (!div_trial[NB_DATA]) begin
                        acc_d = div_trial[NB_DATA-1:0];
                        q_d   = {q_q[NB_DATA-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[NB_DATA-1:0];
                        q_d   = {q_q[NB_DATA-2:0], 1'b0};
                    end
                    if (cnt_q == NB_CNT'(NB_DATA - 1)) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d = cnt_q + NB_CNT'(1);
                    end
                end
            end

            StFinish: begin
                if (dz_q) begin
                    hi_d = q_q;
                    lo_d = '1;
                end else if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
                end else begin
                    lo_d = neg_res_q ? -q_q : q_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StFinish);
    assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, divide-by-zero, stall, flush, reset.
module tb_muldiv_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.NB_DATA(32)) bus ();

    muldiv_sequencer #(
        .NB_DATA (32),
        .NB_CNT  (5)
    ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    int busy_n;
    int done_n;
    int done_at;
    int seen_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op for one cycle, then follow it until the sequencer is idle again.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int ndone, output int at);
        bus.op      = op;
        bus.data_ra = a;
        bus.data_rb = b;
        bus.start   = 1'b1;
        chk("stall_in_idle", 64'(bus.stall), 64'd0);
        tick();
        bus.start = 1'b0;
        nbusy = 0;
        ndone = 0;
        at    = 0;
        while (bus.busy && nbusy < 100) begin
            nbusy++;
            if (bus.done) begin
                ndone++;
                at = nbusy;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_ra = '0;
        bus.data_rb = '0;
        bus.hilo_rd = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.flush   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_hi", 64'(bus.hi), 64'h0);
        chk("rst_lo", 64'(bus.lo), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: MULT 7 * -3
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, busy_n, done_n, done_at);
        chk("mult_busy_cycles", 64'(busy_n), 64'd33);
        chk("mult_done_count", 64'(done_n), 64'd1);
        chk("mult_done_last", 64'(done_at), 64'd33);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        // 2: MULTU max*max, DIVU 100/7
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_n, done_n, done_at);
        chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo), 64'h0000_0001);
        run_op(2'b11, 32'd100, 32'd7, busy_n, done_n, done_at);
        chk("divu_busy_cycles", 64'(busy_n), 64'd33);
        chk("divu_lo", 64'(bus.lo), 64'd14);
        chk("divu_hi", 64'(bus.hi), 64'd2);

        // 3: DIV -7/2 and most-negative / -1
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, busy_n, done_n, done_at);
        chk("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, busy_n, done_n, done_at);
        chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.hi), 64'h0);

        // 4: DIVU by zero
        run_op(2'b11, 32'h1234_5678, 32'h0, busy_n, done_n, done_at);
        chk("dz_busy_cycles", 64'(busy_n), 64'd1);
        chk("dz_done_at", 64'(done_at), 64'd1);
        chk("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(bus.hi), 64'h1234_5678);

        // MTHI / MTLO in idle
        bus.data_ra = 32'h1111_1111;
        bus.wr_hi   = 1'b1;
        tick();
        bus.wr_hi   = 1'b0;
        chk("mthi", 64'(bus.hi), 64'h1111_1111);
        bus.data_ra = 32'h2222_2222;
        bus.wr_lo   = 1'b1;
        tick();
        bus.wr_lo   = 1'b0;
        chk("mtlo", 64'(bus.lo), 64'h2222_2222);

        // 6a: flush a DIV at cycle 10
        bus.op      = 2'b10;
        bus.data_ra = 32'd1000;
        bus.data_rb = 32'd3;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        seen_done   = 0;
        for (int i = 1; i < 10; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        chk("flush_still_idle", 64'(bus.busy), 64'd0);
        chk("flush_hi_kept", 64'(bus.hi), 64'h1111_1111);
        chk("flush_lo_kept", 64'(bus.lo), 64'h2222_2222);

        // 5: MFHI held while a MULT (-5 * 2^28) runs
        bus.op      = 2'b00;
        bus.data_ra = 32'hFFFF_FFFB;
        bus.data_rb = 32'h1000_0000;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            chk($sformatf("stall_cyc%0d", i), 64'(bus.stall), (i <= 33) ? 64'd1 : 64'd0);
            if (i == 34) begin
                chk("stall_read_hi", 64'(bus.hi), 64'hFFFF_FFFF);
                chk("stall_read_lo", 64'(bus.lo), 64'hB000_0000);
            end
            tick();
        end
        bus.hilo_rd = 1'b0;

        // 6b: reset mid-CALC
        bus.op      = 2'b01;
        bus.data_ra = 32'hFFFF_FFFF;
        bus.data_rb = 32'hFFFF_FFFF;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_hi", 64'(bus.hi), 64'h0);
        chk("midrst_lo", 64'(bus.lo), 64'h0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
